// File: rtl/deco_pkg.sv
// Shared types, field positions and decode helpers for the decode stage.
// Optional scoreboard build switch: DECO_MARCADOR_EN.
package deco_pkg;

  localparam int NUM_REG = 16;
  localparam logic [3:0] REG_PC = 4'd15;

  localparam int F_COND  = 28;
  localparam int F_CLASE = 26;
  localparam int F_OP    = 22;
  localparam int F_RD    = 18;
  localparam int F_RN    = 14;
  localparam int F_RM    = 10;

  typedef enum logic [1:0] {
    REG   = 2'b00,
    IMM   = 2'b01,
    MEM   = 2'b10,
    SALTO = 2'b11
  } clase_e;

  typedef enum logic [1:0] {
    VACIO  = 2'b00,
    ESPERA = 2'b01,
    LISTO  = 2'b10
  } estado_e;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  clase;
    logic [3:0]  alu_op;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [3:0]  addr3;
    logic        enable;
    logic [31:0] imm;
    logic [31:0] pc;
  } deco_t;

  function automatic logic lee_rn(input logic [1:0] c);
    return c != SALTO;
  endfunction

  function automatic logic lee_rm(input logic [1:0] c);
    return (c == REG) || (c == MEM);
  endfunction

  function automatic deco_t decodificar(
    input logic [31:0] instr,
    input logic [31:0] pc_in
  );
    deco_t d;
    d        = '0;
    d.cond   = instr[F_COND +: 4];
    d.clase  = instr[F_CLASE +: 2];
    d.alu_op = instr[F_OP +: 4];
    d.pc     = pc_in + 32'd8;
    unique case (clase_e'(d.clase))
      REG: begin
        d.addr1  = instr[F_RN +: 4];
        d.addr2  = instr[F_RM +: 4];
        d.addr3  = instr[F_RD +: 4];
        d.enable = 1'b1;
      end
      IMM: begin
        d.addr1  = instr[F_RN +: 4];
        d.addr3  = instr[F_RD +: 4];
        d.enable = 1'b1;
        d.imm    = {{20{instr[11]}}, instr[11:0]};
      end
      MEM: begin
        d.addr1 = instr[F_RN +: 4];
        d.addr2 = instr[F_RM +: 4];
        if (instr[F_OP]) begin
          d.addr3  = instr[F_RD +: 4];
          d.enable = 1'b1;
        end
      end
      SALTO: begin
        d.imm = {{8{instr[21]}}, instr[21:0], 2'b00};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/etapa_decodificacion_marcador.sv
// Pending-write mask for the 16 registers with a three-address hazard query.
// Only instantiated when DECO_MARCADOR_EN is defined.
module marcador_registros
  import deco_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_set_en,
  input  logic [3:0] i_set_addr,
  input  logic       i_clr_en,
  input  logic [3:0] i_clr_addr,
  input  logic [3:0] i_addr1,
  input  logic [3:0] i_addr2,
  input  logic [3:0] i_addr3,
  input  logic [2:0] i_usa,
  output logic       o_hazard
);

  logic [NUM_REG-1:0] r_pend;
  logic [NUM_REG-1:0] w_set;
  logic [NUM_REG-1:0] w_clr;
  logic [NUM_REG-1:0] w_vista;

  // One-hot set/clear masks; R15 never becomes pending
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_en && i_set_addr != REG_PC) w_set[i_set_addr] = 1'b1;
    if (i_clr_en) w_clr[i_clr_addr] = 1'b1;
    w_vista = r_pend | w_set;
  end

  // A write issuing this cycle is visible to the word entering behind it
  always_comb begin
    o_hazard = 1'b0;
    if (i_usa[0] && i_addr1 != REG_PC && w_vista[i_addr1]) o_hazard = 1'b1;
    if (i_usa[1] && i_addr2 != REG_PC && w_vista[i_addr2]) o_hazard = 1'b1;
    if (i_usa[2] && i_addr3 != REG_PC && w_vista[i_addr3]) o_hazard = 1'b1;
  end

  // Set wins over a same-cycle clear of the same register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_pend <= '0;
    else          r_pend <= (r_pend & ~w_clr) | w_set;
  end

endmodule

// File: rtl/etapa_decodificacion.sv
// Decode stage: one-entry register with valid/ready and hazard stalls.
// Scoreboard and ESPERA state exist only with DECO_MARCADOR_EN defined.
module etapa_decodificacion
  import deco_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  addr1,
  output logic [3:0]  addr2,
  output logic [3:0]  addr3,
  output logic        enable,
  output logic [1:0]  clase,
  output logic [3:0]  alu_op,
  output logic [3:0]  cond,
  output logic [31:0] imm,
  output logic [31:0] pc
);

  estado_e r_estado;
  estado_e w_estado_sig;
  deco_t   r_deco;
  deco_t   w_deco;
  logic    w_acepta;
  logic    w_emite;
  logic    w_hazard;

  assign w_deco    = decodificar(in_instr, in_pc);
  assign out_valid = (r_estado == LISTO);
  assign w_acepta  = in_valid && in_ready;
  assign w_emite   = out_valid && out_ready && !flush;

  assign addr1  = r_deco.addr1;
  assign addr2  = r_deco.addr2;
  assign addr3  = r_deco.addr3;
  assign enable = r_deco.enable;
  assign clase  = r_deco.clase;
  assign alu_op = r_deco.alu_op;
  assign cond   = r_deco.cond;
  assign imm    = r_deco.imm;
  assign pc     = r_deco.pc;

`ifdef DECO_MARCADOR_EN
  logic       w_esp;
  logic [3:0] w_q1;
  logic [3:0] w_q2;
  logic [3:0] w_q3;
  logic [2:0] w_usa;

  // Held word is queried while waiting, the incoming word otherwise
  always_comb begin
    w_esp = (r_estado == ESPERA);
    w_q1  = w_esp ? r_deco.addr1 : w_deco.addr1;
    w_q2  = w_esp ? r_deco.addr2 : w_deco.addr2;
    w_q3  = w_esp ? r_deco.addr3 : w_deco.addr3;
    w_usa = w_esp
      ? {r_deco.enable, lee_rm(r_deco.clase), lee_rn(r_deco.clase)}
      : {w_deco.enable, lee_rm(w_deco.clase), lee_rn(w_deco.clase)};
  end

  marcador_registros u_marcador (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_set_en   (w_emite && r_deco.enable),
    .i_set_addr (r_deco.addr3),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_addr),
    .i_addr1    (w_q1),
    .i_addr2    (w_q2),
    .i_addr3    (w_q3),
    .i_usa      (w_usa),
    .o_hazard   (w_hazard)
  );
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_addr};
  assign w_hazard    = 1'b0;
`endif

  // Upstream ready: free slot, or slot draining this cycle
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !flush) begin
      unique case (r_estado)
        VACIO:   in_ready = 1'b1;
        LISTO:   in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next state; flush outranks everything
  always_comb begin
    w_estado_sig = r_estado;
    if (flush) begin
      w_estado_sig = VACIO;
    end else begin
      unique case (r_estado)
        VACIO:
          if (w_acepta)
            w_estado_sig = w_hazard ? ESPERA : LISTO;
        ESPERA:
          if (!w_hazard) w_estado_sig = LISTO;
        LISTO:
          if (out_ready)
            w_estado_sig = !w_acepta ? VACIO
                         : (w_hazard ? ESPERA : LISTO);
        default: w_estado_sig = VACIO;
      endcase
    end
  end

  // State and held decoded word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= VACIO;
      r_deco   <= '0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_acepta) r_deco <= w_deco;
    end
  end

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Directed bench for etapa_decodificacion, both with and without
// DECO_MARCADOR_EN.
module tb_etapa_decodificacion;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  addr3;
  logic        enable;
  logic [1:0]  clase;
  logic [3:0]  alu_op;
  logic [3:0]  cond;
  logic [31:0] imm;
  logic [31:0] pc;

  int checks = 0;
  int failures = 0;

`ifdef DECO_MARCADOR_EN
  localparam logic STALL = 1'b1;
`else
  localparam logic STALL = 1'b0;
`endif

  always #5 clk = ~clk;

  etapa_decodificacion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr1     (addr1),
    .addr2     (addr2),
    .addr3     (addr3),
    .enable    (enable),
    .clase     (clase),
    .alu_op    (alu_op),
    .cond      (cond),
    .imm       (imm),
    .pc        (pc)
  );

  function automatic logic [31:0] mk(
    input logic [3:0]  c,
    input logic [1:0]  cl,
    input logic [3:0]  op,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [13:0] lo
  );
    return {c, cl, op, rd, rn, lo};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_addr = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, addr1, addr2, addr3, enable,
         clase, alu_op, cond, imm, pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b ir=%b a3=%h imm=%h pc=%h exp all 0",
               out_valid, in_ready, addr3, imm, pc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_imm;
    in_instr = mk(4'hE, 2'b01, 4'h2, 4'd3, 4'd2, 14'h0FFF);
    in_pc = 32'h100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, addr1, addr2, addr3, enable} !==
        {1'b1, 4'd2, 4'd0, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL imm_addr got=%h exp=%h",
               {out_valid, addr1, addr2, addr3, enable},
               {1'b1, 4'd2, 4'd0, 4'd3, 1'b1});
    end
    checks++;
    if ({imm, pc, clase, alu_op, cond} !==
        {32'hFFFFFFFF, 32'h108, 2'b01, 4'h2, 4'hE}) begin
      failures++;
      $display("FAIL imm_value got imm=%h pc=%h cl=%h op=%h cd=%h",
               imm, pc, clase, alu_op, cond);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL imm_drain out_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_raw;
    in_instr = mk(4'hE, 2'b10, 4'h0, 4'd0, 4'd3, {4'd1, 10'd0});
    in_pc = 32'h300;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef DECO_MARCADOR_EN
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      failures++;
      $display("FAIL raw_stall got ov/ir=%b exp=00", {out_valid, in_ready});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL raw_hold got=%b exp=0", out_valid);
    end
    wb_valid = 1'b1;
    wb_addr = 4'd3;
    tick();
    wb_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL raw_wb_edge got=%b exp=0", out_valid);
    end
    tick();
`endif
    checks++;
    if ({out_valid, addr1, addr2, addr3, enable} !==
        {1'b1, 4'd3, 4'd1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL raw_release got=%h exp=%h",
               {out_valid, addr1, addr2, addr3, enable},
               {1'b1, 4'd3, 4'd1, 4'd0, 1'b0});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL raw_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1;
    in_instr = mk(4'hE, 2'b00, 4'h1, 4'd7, 4'd1, {4'd2, 10'd0});
    in_pc = 32'h200;
    tick();
    checks++;
    if ({out_valid, addr3, pc} !== {1'b1, 4'd7, 32'h208}) begin
      failures++;
      $display("FAIL b2b_a got a3=%h pc=%h exp 7 208", addr3, pc);
    end
    in_instr = mk(4'hE, 2'b00, 4'h1, 4'd8, 4'd1, {4'd2, 10'd0});
    in_pc = 32'h204;
    tick();
    checks++;
    if ({out_valid, addr3, pc} !== {1'b1, 4'd8, 32'h20C}) begin
      failures++;
      $display("FAIL b2b_b got a3=%h pc=%h exp 8 20c", addr3, pc);
    end
    in_instr = mk(4'hE, 2'b00, 4'h1, 4'd9, 4'd1, {4'd2, 10'd0});
    in_pc = 32'h208;
    tick();
    checks++;
    if ({out_valid, addr3, pc} !== {1'b1, 4'd9, 32'h210}) begin
      failures++;
      $display("FAIL b2b_c got a3=%h pc=%h exp 9 210", addr3, pc);
    end
    out_ready = 1'b0;
    in_instr = mk(4'hE, 2'b00, 4'h1, 4'd10, 4'd1, {4'd2, 10'd0});
    in_pc = 32'h20C;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, addr3, pc} !==
          {1'b1, 1'b0, 4'd9, 32'h210}) begin
        failures++;
        $display("FAIL b2b_stall%0d got ov=%b ir=%b a3=%h pc=%h",
                 i, out_valid, in_ready, addr3, pc);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, addr3, pc} !== {1'b1, 4'd10, 32'h214}) begin
      failures++;
      $display("FAIL b2b_d got a3=%h pc=%h exp a 214", addr3, pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_set_wins;
    in_instr = mk(4'hE, 2'b01, 4'h0, 4'd5, 4'd1, 14'h0010);
    in_pc = 32'h3F0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr = 4'd5;
    tick();
    wb_valid = 1'b0;
    in_instr = mk(4'hE, 2'b10, 4'h0, 4'd0, 4'd5, {4'd1, 10'd0});
    in_pc = 32'h400;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== ~STALL) begin
      failures++;
      $display("FAIL setwins_reader got ov=%b exp=%b", out_valid, ~STALL);
    end
`ifdef DECO_MARCADOR_EN
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
`endif
    checks++;
    if ({out_valid, addr1} !== {1'b1, 4'd5}) begin
      failures++;
      $display("FAIL setwins_release got ov=%b a1=%h exp 1 5",
               out_valid, addr1);
    end
    tick();
  endtask

  task automatic test_flush;
    in_instr = mk(4'hE, 2'b01, 4'h0, 4'd4, 4'd1, 14'h0010);
    in_pc = 32'h4F0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_instr = mk(4'hE, 2'b00, 4'h0, 4'd11, 4'd4, {4'd1, 10'd0});
    in_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== ~STALL) begin
      failures++;
      $display("FAIL flush_pre got ov=%b exp=%b", out_valid, ~STALL);
    end
    flush = 1'b1;
    in_instr = mk(4'hE, 2'b11, 4'h0, 4'hF, 4'hF, 14'h3FFF);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_vacio got ov=%b exp=0", out_valid);
    end
    in_instr = mk(4'hE, 2'b10, 4'h0, 4'd0, 4'd4, {4'd1, 10'd0});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== ~STALL) begin
      failures++;
      $display("FAIL flush_bit4_kept got ov=%b exp=%b", out_valid, ~STALL);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    in_instr = mk(4'hE, 2'b11, 4'h0, 4'hF, 4'hF, 14'h3FFF);
    in_pc = 32'h500;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, addr1, addr2, addr3, enable, clase} !==
        {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b11}) begin
      failures++;
      $display("FAIL branch_addr got=%h",
               {out_valid, addr1, addr2, addr3, enable, clase});
    end
    checks++;
    if ({imm, pc} !== {32'hFFFFFFFC, 32'h508}) begin
      failures++;
      $display("FAIL branch_imm got imm=%h pc=%h exp fffffffc 508",
               imm, pc);
    end
    tick();
  endtask

  task automatic test_r15;
    in_instr = mk(4'hE, 2'b01, 4'h0, 4'd15, 4'd1, 14'h0010);
    in_pc = 32'h600;
    in_valid = 1'b1;
    tick();
    checks++;
    if ({out_valid, addr3, enable} !== {1'b1, 4'd15, 1'b1}) begin
      failures++;
      $display("FAIL r15_write got ov=%b a3=%h en=%b",
               out_valid, addr3, enable);
    end
    in_instr = mk(4'hE, 2'b00, 4'h0, 4'd12, 4'd15, {4'd1, 10'd0});
    in_pc = 32'h604;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, addr1, addr2, addr3, pc} !==
        {1'b1, 4'd15, 4'd1, 4'd12, 32'h60C}) begin
      failures++;
      $display("FAIL r15_read got ov=%b a1=%h a3=%h pc=%h",
               out_valid, addr1, addr3, pc);
    end
    tick();
  endtask

  task automatic test_mid_reset;
    in_instr = mk(4'hE, 2'b00, 4'h0, 4'd13, 4'd4, {4'd1, 10'd0});
    in_pc = 32'h700;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({out_valid, in_ready, addr1, addr3, enable, pc} !== '0) begin
      failures++;
      $display("FAIL midreset got ov=%b a1=%h a3=%h pc=%h",
               out_valid, addr1, addr3, pc);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, addr1, pc} !== {1'b1, 4'd4, 32'h708}) begin
      failures++;
      $display("FAIL midreset_clear got ov=%b a1=%h pc=%h",
               out_valid, addr1, pc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_imm();
    test_raw();
    test_back_to_back();
    test_set_wins();
    test_flush();
    test_r15();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
